// File: rtl/bp_gshare_ckpt_if.sv
// Fetch/retire bundle for the gshare predictor.
// The master side drives fetch and retire requests; the slave side is the predictor.
interface bp_gshare_ckpt_if #(
    parameter int CW = 3
);
    logic          enable;
    logic          if_branch;
    logic [31:0]   if_pc;
    logic          rt_en_branch;
    logic          rt_taken;
    logic          rt_mispredict;
    logic [31:0]   rt_pc;
    logic [31:0]   rt_target;
    logic [CW-1:0] rt_ckpt_idx;
    logic          pred_valid;
    logic          pred_taken;
    logic [31:0]   next_pc;
    logic [CW-1:0] pred_ckpt_idx;
    logic          ckpt_full;
    logic          err;

    modport master (
        output enable, if_branch, if_pc,
        output rt_en_branch, rt_taken, rt_mispredict, rt_pc, rt_target, rt_ckpt_idx,
        input  pred_valid, pred_taken, next_pc, pred_ckpt_idx, ckpt_full, err
    );

    modport slave (
        input  enable, if_branch, if_pc,
        input  rt_en_branch, rt_taken, rt_mispredict, rt_pc, rt_target, rt_ckpt_idx,
        output pred_valid, pred_taken, next_pc, pred_ckpt_idx, ckpt_full, err
    );
endinterface

// File: rtl/bp_gshare_ckpt.sv
// Gshare predictor with direct-mapped BTB and a checkpoint queue holding the
// global history seen by each in-flight branch, used to repair history on mispredict.
module bp_gshare_ckpt #(
    parameter int BTB_ROWS   = 32,
    parameter int TAG_W      = 10,
    parameter int TARGET_W   = 30,
    parameter int HIST_W     = 8,
    parameter int CKPT_DEPTH = 8
) (
    input logic            clock,
    input logic            reset,
    bp_gshare_ckpt_if.slave bp
);
    localparam int IW    = $clog2(BTB_ROWS);
    localparam int CW    = $clog2(CKPT_DEPTH);
    localparam int PHT_N = 1 << HIST_W;

    logic [1:0]          pht_q     [PHT_N];
    logic [1:0]          pht_d     [PHT_N];
    logic [TAG_W-1:0]    btb_tag_q [BTB_ROWS];
    logic [TAG_W-1:0]    btb_tag_d [BTB_ROWS];
    logic [TARGET_W-1:0] btb_tgt_q [BTB_ROWS];
    logic [TARGET_W-1:0] btb_tgt_d [BTB_ROWS];
    logic [HIST_W-1:0]   ckpt_q    [CKPT_DEPTH];
    logic [HIST_W-1:0]   ckpt_d    [CKPT_DEPTH];
    logic [BTB_ROWS-1:0] btb_valid_q, btb_valid_d;
    logic [HIST_W-1:0]   ghr_q, ghr_d;
    logic [CW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW:0]         count_q, count_d;
    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [31:0]         next_pc_q, next_pc_d;
    logic [CW-1:0]       pred_ckpt_idx_q, pred_ckpt_idx_d;
    logic                err_q, err_d;

    logic [IW-1:0]     f_idx, r_idx;
    logic [TAG_W-1:0]  f_tag, r_tag;
    logic [HIST_W-1:0] f_pht_idx, r_pht_idx, r_hist;
    logic              f_dir, f_hit, f_taken, ckpt_full;
    logic [31:0]       f_tgt_pc;
    logic              issue, pop, rt_bad, rt_flush;
    logic              unused_ok;

    assign unused_ok = ^{bp.rt_pc[31:TAG_W+IW+2], bp.rt_pc[1:0], bp.rt_target[1:0]};

    // Fetch-side lookup: reads only registered tables, so same-cycle training is not visible.
    assign f_idx     = bp.if_pc[IW+1:2];
    assign f_tag     = bp.if_pc[TAG_W+IW+1:IW+2];
    assign f_pht_idx = bp.if_pc[HIST_W+1:2] ^ ghr_q;
    assign f_dir     = pht_q[f_pht_idx][1];
    assign f_hit     = btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);
    assign f_taken   = f_dir & f_hit;
    assign ckpt_full = (count_q == (CW+1)'(CKPT_DEPTH));

    always_comb begin
        f_tgt_pc               = bp.if_pc;
        f_tgt_pc[TARGET_W+1:2] = btb_tgt_q[f_idx];
        f_tgt_pc[1:0]          = 2'b00;
    end

    assign r_idx     = bp.rt_pc[IW+1:2];
    assign r_tag     = bp.rt_pc[TAG_W+IW+1:IW+2];
    assign r_hist    = ckpt_q[bp.rt_ckpt_idx];
    assign r_pht_idx = bp.rt_pc[HIST_W+1:2] ^ r_hist;
    assign rt_bad    = (count_q == '0) | (bp.rt_ckpt_idx != head_q);
    assign rt_flush  = bp.rt_en_branch & bp.rt_mispredict;
    assign issue     = bp.enable & bp.if_branch & ~ckpt_full & ~rt_flush;

    always_comb begin
        pht_d           = pht_q;
        btb_tag_d       = btb_tag_q;
        btb_tgt_d       = btb_tgt_q;
        btb_valid_d     = btb_valid_q;
        ckpt_d          = ckpt_q;
        ghr_d           = ghr_q;
        head_d          = head_q;
        tail_d          = tail_q;
        err_d           = err_q;
        pred_valid_d    = pred_valid_q;
        pred_taken_d    = pred_taken_q;
        next_pc_d       = next_pc_q;
        pred_ckpt_idx_d = pred_ckpt_idx_q;
        pop             = 1'b0;

        if (bp.rt_en_branch) begin
            if (bp.rt_taken && pht_q[r_pht_idx] != 2'b11)
                pht_d[r_pht_idx] = pht_q[r_pht_idx] + 2'b01;
            else if (!bp.rt_taken && pht_q[r_pht_idx] != 2'b00)
                pht_d[r_pht_idx] = pht_q[r_pht_idx] - 2'b01;
            if (bp.rt_taken) begin
                btb_valid_d[r_idx] = 1'b1;
                btb_tag_d[r_idx]   = r_tag;
                btb_tgt_d[r_idx]   = bp.rt_target[TARGET_W+1:2];
            end
            if (rt_bad)
                err_d = 1'b1;
            // Recovery restarts the queue just past the mispredicted branch.
            if (bp.rt_mispredict) begin
                ghr_d  = {r_hist[HIST_W-2:0], bp.rt_taken};
                head_d = bp.rt_ckpt_idx + CW'(1);
                tail_d = bp.rt_ckpt_idx + CW'(1);
            end else if (!rt_bad) begin
                head_d = head_q + CW'(1);
                pop    = 1'b1;
            end
        end

        if (issue) begin
            ckpt_d[tail_q]  = ghr_q;
            tail_d          = tail_q + CW'(1);
            ghr_d           = {ghr_q[HIST_W-2:0], f_dir};
            pred_ckpt_idx_d = tail_q;
        end

        if (bp.enable) begin
            pred_valid_d = issue;
            pred_taken_d = issue & f_taken;
            next_pc_d    = (issue & f_taken) ? f_tgt_pc : bp.if_pc + 32'd4;
        end

        if (rt_flush)
            count_d = '0;
        else
            count_d = count_q + (CW+1)'(issue) - (CW+1)'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++)      pht_q[i]     <= 2'b01;
            for (int i = 0; i < BTB_ROWS; i++)   btb_tag_q[i] <= '0;
            for (int i = 0; i < BTB_ROWS; i++)   btb_tgt_q[i] <= '0;
            for (int i = 0; i < CKPT_DEPTH; i++) ckpt_q[i]    <= '0;
            btb_valid_q     <= '0;
            ghr_q           <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            next_pc_q       <= '0;
            pred_ckpt_idx_q <= '0;
            err_q           <= 1'b0;
        end else begin
            pht_q           <= pht_d;
            btb_tag_q       <= btb_tag_d;
            btb_tgt_q       <= btb_tgt_d;
            ckpt_q          <= ckpt_d;
            btb_valid_q     <= btb_valid_d;
            ghr_q           <= ghr_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            next_pc_q       <= next_pc_d;
            pred_ckpt_idx_q <= pred_ckpt_idx_d;
            err_q           <= err_d;
        end
    end

    assign bp.pred_valid    = pred_valid_q;
    assign bp.pred_taken    = pred_taken_q;
    assign bp.next_pc       = next_pc_q;
    assign bp.pred_ckpt_idx = pred_ckpt_idx_q;
    assign bp.ckpt_full     = ckpt_full;
    assign bp.err           = err_q;
endmodule

// File: tb/tb_bp_gshare_ckpt.sv
// Self-checking bench for bp_gshare_ckpt: directed scenarios plus random traffic
// compared against a table-level model of the predictor.
module tb_bp_gshare_ckpt;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errs = 0;
    int   checks = 0;

    bp_gshare_ckpt_if #(.CW(3)) bp();

    bp_gshare_ckpt dut (.clock(clock), .reset(reset), .bp(bp.slave));

    always #5 clock = ~clock;

    // Reference model state
    int          m_pht [256];
    bit          m_bv [32];
    int          m_btag [32];
    logic [31:0] m_btgt [32];
    int          m_ckpt [8];
    int          m_ghr, m_head, m_tail, m_count;
    bit          m_err;
    logic        exp_valid, exp_taken, exp_full, exp_err;
    logic [31:0] exp_npc;
    logic [2:0]  exp_idx;

    task automatic model_init();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 32; i++) begin m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; end
        for (int i = 0; i < 8; i++) m_ckpt[i] = 0;
        m_ghr = 0; m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
        exp_valid = 0; exp_taken = 0; exp_full = 0; exp_err = 0; exp_npc = 0; exp_idx = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bp.enable = 0; bp.if_branch = 0; bp.if_pc = 0;
        bp.rt_en_branch = 0; bp.rt_taken = 0; bp.rt_mispredict = 0;
        bp.rt_pc = 0; bp.rt_target = 0; bp.rt_ckpt_idx = 0;
        model_init();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model, then sample just after the edge.
    task automatic cycle(input bit en, input bit br, input logic [31:0] pc,
                         input bit re, input bit rtk, input bit rmis,
                         input logic [31:0] rpc, input logic [31:0] rtgt, input int ridx);
        int pidx, bidx, h, ri, rb, g0;
        bit full, mis, iss, dir, hit, bad;
        @(negedge clock);
        bp.enable = en; bp.if_branch = br; bp.if_pc = pc;
        bp.rt_en_branch = re; bp.rt_taken = rtk; bp.rt_mispredict = rmis;
        bp.rt_pc = rpc; bp.rt_target = rtgt; bp.rt_ckpt_idx = ridx[2:0];

        full = (m_count == 8);
        mis  = re && rmis;
        iss  = en && br && !full && !mis;
        pidx = ((pc >> 2) & 255) ^ m_ghr;
        dir  = (m_pht[pidx] >= 2);
        bidx = (pc >> 2) & 31;
        hit  = m_bv[bidx] && (m_btag[bidx] == ((pc >> 7) & 1023));
        if (en) begin
            exp_valid = iss;
            exp_taken = iss && dir && hit;
            exp_npc   = exp_taken ? (m_btgt[bidx] & ~32'h3) : pc + 32'd4;
            if (iss) exp_idx = m_tail[2:0];
        end
        g0 = m_ghr;
        if (re) begin
            bad = (m_count == 0) || (ridx != m_head);
            if (bad) m_err = 1;
            h  = m_ckpt[ridx];
            ri = ((rpc >> 2) & 255) ^ h;
            if (rtk) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
            else     m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
            if (rtk) begin
                rb = (rpc >> 2) & 31;
                m_bv[rb] = 1; m_btag[rb] = (rpc >> 7) & 1023; m_btgt[rb] = rtgt;
            end
            if (rmis) begin
                m_ghr = ((h << 1) | int'(rtk)) & 255;
                m_head = (ridx + 1) % 8; m_tail = m_head; m_count = 0;
            end else if (!bad) begin
                m_head = (m_head + 1) % 8; m_count--;
            end
        end
        if (iss) begin
            m_ckpt[m_tail] = g0;
            m_tail = (m_tail + 1) % 8;
            m_count++;
            m_ghr = ((g0 << 1) | int'(dir)) & 255;
        end
        exp_full = (m_count == 8);
        exp_err  = m_err;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc);
        cycle(1, 1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input int idx, input bit tk, input bit mis,
                          input logic [31:0] rpc, input logic [31:0] tgt);
        cycle(1, 0, 0, 1, tk, mis, rpc, tgt, idx);
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clock); #1;
        checks++; if (bp.pred_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %0b want 0", bp.pred_valid); end
        checks++; if (bp.next_pc !== 32'h0) begin errs++; $display("FAIL reset_npc: got %0h want 0", bp.next_pc); end
        checks++; if (bp.ckpt_full !== 1'b0 || bp.err !== 1'b0 || bp.pred_taken !== 1'b0 || bp.pred_ckpt_idx !== 3'd0) begin
            errs++; $display("FAIL reset_misc: got full=%0b err=%0b tk=%0b idx=%0d want 0", bp.ckpt_full, bp.err, bp.pred_taken, bp.pred_ckpt_idx);
        end
        // Asynchronous reset in the middle of a cycle clears outputs before the next edge.
        issue(32'h100);
        issue(32'h104);
        #2 reset = 1'b0;
        #1;
        checks++; if (bp.pred_valid !== 1'b0 || bp.next_pc !== 32'h0 || bp.pred_ckpt_idx !== 3'd0) begin
            errs++; $display("FAIL async_reset: got v=%0b npc=%0h idx=%0d want 0", bp.pred_valid, bp.next_pc, bp.pred_ckpt_idx);
        end
    endtask

    task automatic test_first_issue();
        do_reset();
        issue(32'h100);
        checks++; if (bp.pred_valid !== 1'b1 || bp.pred_taken !== 1'b0) begin
            errs++; $display("FAIL first_dir: got v=%0b t=%0b want v=1 t=0", bp.pred_valid, bp.pred_taken);
        end
        checks++; if (bp.next_pc !== 32'h104 || bp.pred_ckpt_idx !== 3'd0) begin
            errs++; $display("FAIL first_pc: got npc=%0h idx=%0d want 104 idx=0", bp.next_pc, bp.pred_ckpt_idx);
        end
        cycle(0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
        checks++; if (bp.next_pc !== 32'h104 || bp.pred_valid !== 1'b1) begin
            errs++; $display("FAIL hold_disabled: got npc=%0h v=%0b want 104 v=1", bp.next_pc, bp.pred_valid);
        end
        cycle(1, 0, 32'h500, 0, 0, 0, 0, 0, 0);
        checks++; if (bp.next_pc !== 32'h504 || bp.pred_valid !== 1'b0) begin
            errs++; $display("FAIL no_branch: got npc=%0h v=%0b want 504 v=0", bp.next_pc, bp.pred_valid);
        end
    endtask

    task automatic test_train();
        do_reset();
        issue(32'h100);
        issue(32'h100);
        retire(0, 1, 0, 32'h100, 32'h200);
        retire(1, 1, 0, 32'h100, 32'h200);
        issue(32'h100);
        checks++; if (bp.pred_taken !== 1'b1 || bp.next_pc !== 32'h200) begin
            errs++; $display("FAIL train_taken: got t=%0b npc=%0h want t=1 npc=200", bp.pred_taken, bp.next_pc);
        end
        checks++; if (bp.pred_ckpt_idx !== exp_idx || bp.err !== exp_err) begin
            errs++; $display("FAIL train_idx: got idx=%0d err=%0b want idx=%0d err=%0b", bp.pred_ckpt_idx, bp.err, exp_idx, exp_err);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) issue(32'h1000 + 32'(i * 4));
        checks++; if (bp.ckpt_full !== 1'b1) begin errs++; $display("FAIL full_set: got %0b want 1", bp.ckpt_full); end
        issue(32'h2000);
        checks++; if (bp.pred_valid !== 1'b0 || bp.next_pc !== 32'h2004) begin
            errs++; $display("FAIL full_block: got v=%0b npc=%0h want v=0 npc=2004", bp.pred_valid, bp.next_pc);
        end
        cycle(1, 1, 32'h2000, 1, 0, 0, 32'h1000, 0, 0);
        checks++; if (bp.pred_valid !== 1'b0 || bp.ckpt_full !== 1'b0) begin
            errs++; $display("FAIL full_same_cycle: got v=%0b full=%0b want v=0 full=0", bp.pred_valid, bp.ckpt_full);
        end
        issue(32'h2000);
        checks++; if (bp.pred_valid !== 1'b1 || bp.pred_ckpt_idx !== 3'd0 || bp.ckpt_full !== 1'b1) begin
            errs++; $display("FAIL full_wrap: got v=%0b idx=%0d full=%0b want v=1 idx=0 full=1", bp.pred_valid, bp.pred_ckpt_idx, bp.ckpt_full);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(32'h100);
        retire(0, 1, 0, 32'h100, 32'h300);
        issue(32'h100);
        issue(32'h204);
        issue(32'h308);
        retire(1, 1, 1, 32'h100, 32'h300);
        checks++; if (bp.ckpt_full !== 1'b0 || bp.err !== 1'b0) begin
            errs++; $display("FAIL mis_state: got full=%0b err=%0b want 0 0", bp.ckpt_full, bp.err);
        end
        issue(32'h108);
        checks++; if (bp.pred_ckpt_idx !== 3'd2 || bp.pred_valid !== 1'b1) begin
            errs++; $display("FAIL mis_tail: got idx=%0d v=%0b want idx=2 v=1", bp.pred_ckpt_idx, bp.pred_valid);
        end
        checks++; if (bp.pred_taken !== exp_taken || bp.next_pc !== exp_npc) begin
            errs++; $display("FAIL mis_ghr: got t=%0b npc=%0h want t=%0b npc=%0h", bp.pred_taken, bp.next_pc, exp_taken, exp_npc);
        end
        // A mispredict on the same cycle as a fetch branch drops the issue.
        cycle(1, 1, 32'h400, 1, 0, 1, 32'h108, 0, 2);
        checks++; if (bp.pred_valid !== 1'b0 || bp.next_pc !== 32'h404) begin
            errs++; $display("FAIL mis_drop: got v=%0b npc=%0h want v=0 npc=404", bp.pred_valid, bp.next_pc);
        end
        issue(32'h400);
        checks++; if (bp.pred_ckpt_idx !== 3'd3) begin
            errs++; $display("FAIL mis_drop_tail: got idx=%0d want 3", bp.pred_ckpt_idx);
        end
    endtask

    task automatic test_err();
        do_reset();
        issue(32'h100);
        retire(5, 0, 0, 32'h100, 0);
        checks++; if (bp.err !== 1'b1) begin errs++; $display("FAIL err_idx: got %0b want 1", bp.err); end
        retire(0, 0, 0, 32'h100, 0);
        issue(32'h100);
        checks++; if (bp.err !== 1'b1 || bp.pred_ckpt_idx !== 3'd1) begin
            errs++; $display("FAIL err_sticky: got err=%0b idx=%0d want err=1 idx=1", bp.err, bp.pred_ckpt_idx);
        end
        do_reset();
        retire(0, 0, 0, 32'h100, 0);
        checks++; if (bp.err !== 1'b1) begin errs++; $display("FAIL err_empty: got %0b want 1", bp.err); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) issue(32'h3A0);
        for (int i = 0; i < 4; i++) retire(i, 1, 0, 32'h3A0, 32'h1234_5670);
        retire(4, 0, 0, 32'h3A0, 32'h0);
        issue(32'h3A0);
        checks++; if (bp.pred_taken !== 1'b1 || bp.next_pc !== 32'h1234_5670) begin
            errs++; $display("FAIL saturate: got t=%0b npc=%0h want t=1 npc=12345670", bp.pred_taken, bp.next_pc);
        end
    endtask

    task automatic test_random();
        bit en, br, re, tk, mis;
        logic [31:0] pc, rpc, tgt;
        int ridx;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            br  = $urandom_range(0, 1);
            pc  = (32'($urandom_range(0, 63)) << 2) | ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
            re  = (m_count > 0) && ($urandom_range(0, 2) == 0);
            tk  = $urandom_range(0, 1);
            mis = ($urandom_range(0, 5) == 0);
            rpc = (32'($urandom_range(0, 63)) << 2) | ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
            tgt = $urandom & 32'hFFFF_FFFC;
            ridx = m_head;
            if (i > 550 && $urandom_range(0, 9) == 0) ridx = $urandom_range(0, 7);
            cycle(en, br, pc, re, tk, re && mis, rpc, tgt, ridx);
            checks++; if (bp.pred_valid !== exp_valid) begin errs++; $display("FAIL rand_valid c%0d: got %0b want %0b", i, bp.pred_valid, exp_valid); end
            checks++; if (bp.pred_taken !== exp_taken) begin errs++; $display("FAIL rand_taken c%0d: got %0b want %0b", i, bp.pred_taken, exp_taken); end
            checks++; if (bp.next_pc !== exp_npc) begin errs++; $display("FAIL rand_npc c%0d: got %0h want %0h", i, bp.next_pc, exp_npc); end
            checks++; if (bp.pred_ckpt_idx !== exp_idx) begin errs++; $display("FAIL rand_idx c%0d: got %0d want %0d", i, bp.pred_ckpt_idx, exp_idx); end
            checks++; if (bp.ckpt_full !== exp_full) begin errs++; $display("FAIL rand_full c%0d: got %0b want %0b", i, bp.ckpt_full, exp_full); end
            checks++; if (bp.err !== exp_err) begin errs++; $display("FAIL rand_err c%0d: got %0b want %0b", i, bp.err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_train();
        test_full();
        test_mispredict();
        test_err();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
